// File: rtl/data_bus_bridge_if.sv
// Processor data-port bus between the CPU and the data bus bridge.
interface data_bus_bridge_if #(
  parameter int unsigned DATA_W = 16
);
  logic [15:0]       DataAddr;
  logic [DATA_W-1:0] DataOut;
  logic              WriteData;
  logic              ReadData;
  logic [DATA_W-1:0] DataIn;
  logic              DataWaitreq;

  // Processor side: issues requests, receives read data and stalls.
  modport master (
    output DataAddr, DataOut, WriteData, ReadData,
    input  DataIn, DataWaitreq
  );

  // Bridge side: decodes requests, returns read data and stalls.
  modport slave (
    input  DataAddr, DataOut, WriteData, ReadData,
    output DataIn, DataWaitreq
  );
endinterface

// File: rtl/data_bus_bridge.sv
// Data bus bridge: routes processor data accesses to a synchronous RAM or to
// memory-mapped board I/O, adds one wait state for RAM reads and counts
// accesses to unmapped addresses.
module data_bus_bridge #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RAM_AW      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  data_bus_bridge_if.slave  bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  input  logic [9:0]        SW,
  input  logic [3:0]        KEY,
  output logic [9:0]        LEDR,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5
);

  localparam int unsigned LED_W   = 10;
  localparam int unsigned HEX_W   = 7;
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned NUM_HEX = 6;
  localparam int unsigned ERR_W   = 16;

  localparam logic [15:0] ADDR_LED  = 16'h1000;
  localparam logic [12:0] HEX_PAGE  = 13'h0400;  // 0x2000 >> 3
  localparam logic [15:0] ADDR_SW   = 16'h3000;
  localparam logic [15:0] ADDR_KEY  = 16'h3001;
  localparam logic [15:0] ADDR_ERR  = 16'h3002;

  localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [0:0] {IDLE, RD_WAIT} state_e;

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [HEX_W-1:0]  hex_q [NUM_HEX];
  logic [HEX_W-1:0]  hex_d [NUM_HEX];
  logic [ERR_W-1:0]  errcnt_q, errcnt_d;
  logic [LED_W-1:0]  sw_sync_q  [SYNC_STAGES];
  logic [LED_W-1:0]  sw_sync_d  [SYNC_STAGES];
  logic [KEY_W-1:0]  key_sync_q [SYNC_STAGES];
  logic [KEY_W-1:0]  key_sync_d [SYNC_STAGES];

  logic is_ram, is_led, is_hex, is_sw, is_key, is_err;
  logic err_event, err_clear;

  // Address decode of the current request.
  always_comb begin
    is_ram = ((bus.DataAddr >> RAM_AW) == 16'd0);
    is_led = (bus.DataAddr == ADDR_LED);
    is_hex = (bus.DataAddr[15:3] == HEX_PAGE) && (bus.DataAddr[2:0] <= 3'd5);
    is_sw  = (bus.DataAddr == ADDR_SW);
    is_key = (bus.DataAddr == ADDR_KEY);
    is_err = (bus.DataAddr == ADDR_ERR);
  end

  // Synchroniser chains for the asynchronous switch and key inputs.
  always_comb begin
    sw_sync_d[0]  = SW;
    key_sync_d[0] = KEY;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sw_sync_d[i]  = sw_sync_q[i-1];
      key_sync_d[i] = key_sync_q[i-1];
    end
  end

  // Next-state, register updates and bus outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    led_d           = led_q;
    hex_d           = hex_q;
    errcnt_d        = errcnt_q;
    err_event       = 1'b0;
    err_clear       = 1'b0;
    bus.DataIn      = '0;
    bus.DataWaitreq = 1'b0;
    ram_addr        = bus.DataAddr[RAM_AW-1:0];
    ram_wdata       = bus.DataOut;
    ram_wren        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.WriteData) begin
          // A simultaneous read is dropped and flagged as an error.
          if (bus.ReadData) err_event = 1'b1;
          if (is_ram) begin
            ram_wren = 1'b1;
          end else if (is_led) begin
            led_d = LED_W'(bus.DataOut);
          end else if (is_hex) begin
            for (int i = 0; i < NUM_HEX; i++) begin
              if (bus.DataAddr[2:0] == 3'(i)) hex_d[i] = HEX_W'(bus.DataOut);
            end
          end else if (is_err) begin
            err_clear = 1'b1;
          end else if (!is_sw && !is_key) begin
            err_event = 1'b1;
          end
        end else if (bus.ReadData) begin
          if (is_ram) begin
            addr_d          = bus.DataAddr[RAM_AW-1:0];
            bus.DataWaitreq = 1'b1;
            state_d         = RD_WAIT;
          end else if (is_led) begin
            bus.DataIn = DATA_W'(led_q);
          end else if (is_hex) begin
            for (int i = 0; i < NUM_HEX; i++) begin
              if (bus.DataAddr[2:0] == 3'(i)) bus.DataIn = DATA_W'(hex_q[i]);
            end
          end else if (is_sw) begin
            bus.DataIn = DATA_W'(sw_sync_q[SYNC_STAGES-1]);
          end else if (is_key) begin
            bus.DataIn = DATA_W'(key_sync_q[SYNC_STAGES-1]);
          end else if (is_err) begin
            bus.DataIn = DATA_W'(errcnt_q);
          end else begin
            err_event = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        // Requests are ignored here; the captured address completes the read.
        ram_addr   = addr_q;
        bus.DataIn = ram_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a same-cycle error; the count saturates.
    if (err_clear) begin
      errcnt_d = '0;
    end else if (err_event && (errcnt_q != ERR_MAX)) begin
      errcnt_d = errcnt_q + ERR_W'(1);
    end

    // Bus handshake and RAM strobe are held quiet during reset.
    if (!Reset) begin
      bus.DataIn      = '0;
      bus.DataWaitreq = 1'b0;
      ram_wren        = 1'b0;
    end
  end

  // State and register flops with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      led_q    <= '0;
      errcnt_q <= '0;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= HEX_BLANK;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i]  <= '0;
        key_sync_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      led_q      <= led_d;
      errcnt_q   <= errcnt_d;
      hex_q      <= hex_d;
      sw_sync_q  <= sw_sync_d;
      key_sync_q <= key_sync_d;
    end
  end

  // Board-facing register outputs.
  always_comb begin
    LEDR = led_q;
    HEX0 = hex_q[0];
    HEX1 = hex_q[1];
    HEX2 = hex_q[2];
    HEX3 = hex_q[3];
    HEX4 = hex_q[4];
    HEX5 = hex_q[5];
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed self-checking bench for data_bus_bridge.
module tb_data_bus_bridge;

  logic        clk;
  logic        rst_n;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wren;
  logic [15:0] ram_q;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [15:0] ram_mem [4096];

  int n_tests;
  int n_fail;

  data_bus_bridge_if #(.DATA_W(16)) bus ();

  data_bus_bridge #(.DATA_W(16), .RAM_AW(12), .SYNC_STAGES(2)) dut (
    .Clock(clk), .Reset(rst_n), .bus(bus),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .SW(sw), .KEY(key), .LEDR(ledr),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
    ram_q <= ram_mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.DataAddr  = 16'h0000;
    bus.DataOut   = 16'h0000;
    bus.WriteData = 1'b0;
    bus.ReadData  = 1'b0;
  endtask

  task automatic drive_read(input logic [15:0] a);
    bus.DataAddr  = a;
    bus.DataOut   = 16'h0000;
    bus.WriteData = 1'b0;
    bus.ReadData  = 1'b1;
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [15:0] d);
    bus.DataAddr  = a;
    bus.DataOut   = d;
    bus.WriteData = 1'b1;
    bus.ReadData  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_write(16'h0100, 16'hAAAA);
    bus.ReadData = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      n_tests++;
      if (ram_wren !== 1'b0 || bus.DataWaitreq !== 1'b0 || bus.DataIn !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_forced: wren=%b wait=%b din=%h required 0/0/0000",
                 ram_wren, bus.DataWaitreq, bus.DataIn);
      end
      tick();
    end
    rst_n = 1'b1;
    drive_idle();
    #4;
    n_tests++;
    if (ledr !== 10'h000 || hex0 !== 7'h7F || hex1 !== 7'h7F || hex2 !== 7'h7F ||
        hex3 !== 7'h7F || hex4 !== 7'h7F || hex5 !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_regs: ledr=%h hex0..5=%h %h %h %h %h %h required 000 / 7f",
               ledr, hex0, hex1, hex2, hex3, hex4, hex5);
    end
    tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0000 || bus.DataWaitreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_errcnt: din=%h wait=%b required 0000/0", bus.DataIn, bus.DataWaitreq);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_ram_write_read();
    drive_write(16'h0123, 16'hBEEF);
    #4;
    n_tests++;
    if (ram_wren !== 1'b1 || bus.DataWaitreq !== 1'b0 || ram_addr !== 12'h123 ||
        ram_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL ram_write: wren=%b wait=%b addr=%h wdata=%h required 1/0/123/beef",
               ram_wren, bus.DataWaitreq, ram_addr, ram_wdata);
    end
    tick();
    drive_idle();
    #4;
    n_tests++;
    if (ram_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL ram_write_single: wren=%b required 0", ram_wren);
    end
    tick();
    drive_read(16'h0123);
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b1 || ram_addr !== 12'h123 || bus.DataIn !== 16'h0000) begin
      n_fail++;
      $display("FAIL ram_read_c1: wait=%b addr=%h din=%h required 1/123/0000",
               bus.DataWaitreq, ram_addr, bus.DataIn);
    end
    tick();
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b0 || bus.DataIn !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL ram_read_c2: wait=%b din=%h required 0/beef", bus.DataWaitreq, bus.DataIn);
    end
    tick();
    drive_idle();
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0000 || bus.DataWaitreq !== 1'b0) begin
      n_fail++;
      $display("FAIL ram_read_done: din=%h wait=%b required 0000/0", bus.DataIn, bus.DataWaitreq);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_write(16'h0010, 16'h1111);
    tick();
    drive_write(16'h0011, 16'h2222);
    tick();
    drive_read(16'h0010);
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_c1: wait=%b required 1", bus.DataWaitreq);
    end
    tick();
    bus.DataAddr = 16'h0011;
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b0 || bus.DataIn !== 16'h1111 || ram_addr !== 12'h010) begin
      n_fail++;
      $display("FAIL b2b_c2: wait=%b din=%h addr=%h required 0/1111/010",
               bus.DataWaitreq, bus.DataIn, ram_addr);
    end
    tick();
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b1 || ram_addr !== 12'h011) begin
      n_fail++;
      $display("FAIL b2b_c3: wait=%b addr=%h required 1/011", bus.DataWaitreq, ram_addr);
    end
    tick();
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b0 || bus.DataIn !== 16'h2222) begin
      n_fail++;
      $display("FAIL b2b_c4: wait=%b din=%h required 0/2222", bus.DataWaitreq, bus.DataIn);
    end
    tick();
    drive_write(16'h0012, 16'h3333);
    #4;
    n_tests++;
    if (ram_wren !== 1'b1 || bus.DataWaitreq !== 1'b0 || ram_addr !== 12'h012) begin
      n_fail++;
      $display("FAIL write_after_read: wren=%b wait=%b addr=%h required 1/0/012",
               ram_wren, bus.DataWaitreq, ram_addr);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_io();
    drive_write(16'h1000, 16'h03FF);
    tick();
    drive_write(16'h2003, 16'h0040);
    #4;
    n_tests++;
    if (ledr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL ledr_write: ledr=%h required 3ff", ledr);
    end
    tick();
    drive_read(16'h1000);
    #4;
    n_tests++;
    if (hex3 !== 7'h40 || hex2 !== 7'h7F || hex4 !== 7'h7F) begin
      n_fail++;
      $display("FAIL hex_write: hex2=%h hex3=%h hex4=%h required 7f/40/7f", hex2, hex3, hex4);
    end
    n_tests++;
    if (bus.DataIn !== 16'h03FF || bus.DataWaitreq !== 1'b0) begin
      n_fail++;
      $display("FAIL ledr_read: din=%h wait=%b required 03ff/0", bus.DataIn, bus.DataWaitreq);
    end
    tick();
    drive_read(16'h2003);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0040) begin
      n_fail++;
      $display("FAIL hex_read: din=%h required 0040", bus.DataIn);
    end
    tick();
    sw = 10'h155;
    drive_read(16'h3000);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0000) begin
      n_fail++;
      $display("FAIL sw_sync0: din=%h required 0000", bus.DataIn);
    end
    tick();
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0000) begin
      n_fail++;
      $display("FAIL sw_sync1: din=%h required 0000", bus.DataIn);
    end
    tick();
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0155 || bus.DataWaitreq !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_read: din=%h wait=%b required 0155/0", bus.DataIn, bus.DataWaitreq);
    end
    tick();
    key = 4'hA;
    drive_idle();
    tick();
    tick();
    drive_read(16'h3001);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h000A) begin
      n_fail++;
      $display("FAIL key_read: din=%h required 000a", bus.DataIn);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_errors();
    drive_read(16'h4000);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0000 || bus.DataWaitreq !== 1'b0) begin
      n_fail++;
      $display("FAIL unmapped_read: din=%h wait=%b required 0000/0", bus.DataIn, bus.DataWaitreq);
    end
    tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0001) begin
      n_fail++;
      $display("FAIL errcnt_1: errcnt=%h required 0001", bus.DataIn);
    end
    tick();
    drive_write(16'h0005, 16'h1234);
    bus.ReadData = 1'b1;
    #4;
    n_tests++;
    if (ram_wren !== 1'b1 || bus.DataWaitreq !== 1'b0 || bus.DataIn !== 16'h0000) begin
      n_fail++;
      $display("FAIL rw_both: wren=%b wait=%b din=%h required 1/0/0000",
               ram_wren, bus.DataWaitreq, bus.DataIn);
    end
    tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0002) begin
      n_fail++;
      $display("FAIL errcnt_2: errcnt=%h required 0002", bus.DataIn);
    end
    tick();
    drive_read(16'h0005);
    tick();
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h1234) begin
      n_fail++;
      $display("FAIL rw_both_data: din=%h required 1234", bus.DataIn);
    end
    tick();
    drive_write(16'h4000, 16'h0000);
    tick();
    drive_write(16'h3000, 16'h0000);
    tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0003 || ledr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL unmapped_write: errcnt=%h ledr=%h required 0003/3ff", bus.DataIn, ledr);
    end
    tick();
    drive_write(16'h3002, 16'hFFFF);
    tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0000) begin
      n_fail++;
      $display("FAIL errcnt_clear: errcnt=%h required 0000", bus.DataIn);
    end
    tick();
    drive_read(16'h4000);
    tick();
    drive_write(16'h3002, 16'h0000);
    bus.ReadData = 1'b1;
    tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_and_error: errcnt=%h required 0000", bus.DataIn);
    end
    tick();
    drive_read(16'h4000);
    for (int i = 0; i < 65535; i++) tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL errcnt_max: errcnt=%h required ffff", bus.DataIn);
    end
    tick();
    drive_read(16'h4000);
    tick();
    drive_read(16'h3002);
    #4;
    n_tests++;
    if (bus.DataIn !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL errcnt_saturate: errcnt=%h required ffff", bus.DataIn);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_reset_mid_read();
    drive_read(16'h0123);
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_read_c1: wait=%b required 1", bus.DataWaitreq);
    end
    tick();
    rst_n = 1'b0;
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b0 || bus.DataIn !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_in_rdwait: wait=%b din=%h required 0/0000", bus.DataWaitreq, bus.DataIn);
    end
    tick();
    rst_n = 1'b1;
    drive_read(16'h0123);
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b1 || ram_addr !== 12'h123) begin
      n_fail++;
      $display("FAIL rst_next_c1: wait=%b addr=%h required 1/123", bus.DataWaitreq, ram_addr);
    end
    tick();
    #4;
    n_tests++;
    if (bus.DataWaitreq !== 1'b0 || bus.DataIn !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rst_next_c2: wait=%b din=%h required 0/beef", bus.DataWaitreq, bus.DataIn);
    end
    tick();
    drive_idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4096; i++) ram_mem[i] = 16'h0000;
    ram_q = 16'h0000;
    sw    = 10'h000;
    key   = 4'h0;
    rst_n = 1'b0;
    drive_idle();
    tick();
    test_reset();
    test_ram_write_read();
    test_back_to_back();
    test_io();
    test_errors();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
Sits directly downstream of the processor data port. It decodes DataAddr/ReadData/WriteData, routes each access to a synchronous single-port data RAM or to memory-mapped board I/O (LEDR, HEX, SW, KEY), and drives DataIn and DataWaitreq back to the processor. It inserts exactly one wait state for RAM reads and none elsewhere, and it counts accesses to unmapped addresses.

Parameters:
DATA_W, 16, processor data width
RAM_AW, 12, RAM address width; RAM occupies 0x0000 .. 2^RAM_AW-1
SYNC_STAGES, 2, flop depth of the SW/KEY input synchronisers (minimum 2)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
DataAddr  in  16  processor data address
DataOut  in  DATA_W  processor write data
WriteData  in  1  write request
ReadData  in  1  read request
DataIn  out  DATA_W  read data to processor
DataWaitreq  out  1  stall request to processor
ram_addr  out  RAM_AW  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM registered read data, valid 1 cycle after address
SW  in  10  board switches (asynchronous)
KEY  in  4  board keys (asynchronous, active-low)
LEDR  out  10  LED register
HEX0..HEX5  out  7 each  seven-segment registers, active-low segments

Behaviour:
- Address map:
  - RAM: DataAddr < 2^RAM_AW.
  - 0x1000: LEDR (R/W, bits [9:0], upper bits read 0).
  - 0x2000..0x2005: HEX0..HEX5 (R/W, bits [6:0]).
  - 0x3000: SW (R, synchronised, zero-extended).
  - 0x3001: KEY (R, synchronised, zero-extended).
  - 0x3002: ERRCNT (R; any write clears it to 0).
  - Any other address is unmapped.
- Reset (Reset=0 at a rising edge): state=IDLE, LEDR=0, HEX0..5=7'h7F, ERRCNT=0, synchroniser flops=0, captured address=0.
- While Reset=0, outputs are forced: DataWaitreq=0, ram_wren=0, DataIn=0.
- FSM states: IDLE, RD_WAIT.
- IDLE, ReadData=1 to RAM:
  - Capture DataAddr[RAM_AW-1:0]; drive ram_addr from DataAddr combinationally this cycle.
  - DataWaitreq=1; next state RD_WAIT.
- RD_WAIT:
  - ram_addr = captured address; DataIn = ram_q; DataWaitreq=0; next state IDLE.
  - Read latency is 2 cycles, one of them a wait state.
  - Address or request changes while in RD_WAIT are ignored; the captured address is used.
- IDLE, ReadData=1 to I/O or ERRCNT: DataIn driven combinationally from the register, DataWaitreq=0, zero wait.
- IDLE, WriteData=1:
  - Zero wait, DataWaitreq=0.
  - RAM writes: ram_wren=1, ram_addr=DataAddr, ram_wdata=DataOut in the same cycle.
  - I/O registers update at the rising edge; SW/KEY writes are ignored.
- ReadData and WriteData both 1: treated as a write; the read is dropped; ERRCNT increments.
- Unmapped access: read returns 0 with zero wait; write is discarded; ERRCNT increments.
- ERRCNT saturates at 0xFFFF. A clear-write and an error event in the same cycle leave ERRCNT=0.
- Back-to-back RAM reads each cost 2 cycles (RD_WAIT always returns to IDLE).
- A write in the cycle after RD_WAIT is accepted normally.
- Reset asserted during RD_WAIT: next state IDLE, no data returned.
- ram_wren=0 in every cycle except an IDLE RAM write.
- DataIn=0 when no read is completing.

Test Plan:
- Reset: hold Reset=0 for 3 cycles -> LEDR=0, HEX0..5=7'h7F, ERRCNT reads 0, DataWaitreq=0.
- RAM write then read: write 0xBEEF to 0x0123 -> ram_wren=1 for one cycle, no wait. Then read 0x0123 -> DataWaitreq=1 for cycle 1, cycle 2 DataIn=0xBEEF with DataWaitreq=0.
- Back-to-back reads: read 0x0010 then 0x0011 holding each request until DataWaitreq=0 -> 4 cycles total, correct data each time. Address changed mid-RD_WAIT still returns the first address's data.
- I/O: write 0x03FF to 0x1000 -> LEDR=10'h3FF. Write 0x0040 to 0x2003 -> HEX3=7'h40. Set SW=10'h155 -> a read of 0x3000 returns 0x0155 after ≥2 cycles, zero wait.
- Errors: read 0x4000 -> DataIn=0 and ERRCNT=1. Simultaneous Read+Write to 0x0005 -> RAM written and ERRCNT=2. Write to 0x3002 -> ERRCNT=0. Force ERRCNT=0xFFFF and error once more -> stays 0xFFFF.
- Reset mid-read: issue a RAM read, assert Reset=0 during RD_WAIT -> DataWaitreq=0 and state IDLE. The next read after reset completes in 2 cycles.
